// File: rtl/riscv_ctrl_pkg.sv
// Control-word encodings and widths shared by the decode controller and ctrl_pipeline.
// No logic of its own.
package riscv_ctrl_pkg;

  localparam int SEL_RESULT_W = 2;
  localparam int ALU_CTRL_W   = 4;
  localparam int FWD_SEL_W    = 2;

  typedef enum logic [SEL_RESULT_W-1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } sel_result_e;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                    jump;
    logic                    branch;
    logic                    we_dm;
    logic                    sel_alu_src_b;
    logic                    we_rf;
    logic [SEL_RESULT_W-1:0] sel_result;
    logic [ALU_CTRL_W-1:0]   alu_control;
  } ctrl_word_t;

endpackage

// File: rtl/hazard_unit.sv
// Redirect, load-use stall and operand-forwarding decisions for the E/M/W pipeline.
// Purely combinational; stall_F/stall_D are the only backpressure it raises upstream.
module hazard_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          E_jump,
  input  logic          E_branch,
  input  logic          E_zero,
  input  logic [1:0]    E_sel_result,
  input  logic [RW-1:0] E_rd,
  input  logic [RW-1:0] E_rs1,
  input  logic [RW-1:0] E_rs2,
  input  logic [RW-1:0] D_rs1,
  input  logic [RW-1:0] D_rs2,
  input  logic          M_we_rf,
  input  logic [RW-1:0] M_rd,
  input  logic          W_we_rf,
  input  logic [RW-1:0] W_rd,
  output logic          pc_src,
  output logic          flush_E,
  output logic          flush_D,
  output logic          stall_F,
  output logic          stall_D,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  logic lw_stall;

  // M is the younger producer, so it is tested first; x0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] rs,
    input logic          m_we,
    input logic [RW-1:0] m_rd,
    input logic          w_we,
    input logic [RW-1:0] w_rd
  );
    if (rs != '0 && m_we && m_rd == rs)
      return FWD_M;
    else if (rs != '0 && w_we && w_rd == rs)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign pc_src   = E_jump | (E_branch & E_zero);
  assign lw_stall = (E_sel_result == RES_LOAD) && (E_rd != '0) &&
                    ((E_rd == D_rs1) || (E_rd == D_rs2));

  assign flush_E = pc_src | lw_stall;
  assign flush_D = pc_src;
  // A redirect discards the decode instruction anyway, so fetch must not be held.
  assign stall_F = lw_stall & ~pc_src;
  assign stall_D = lw_stall & ~pc_src;

  assign fwd_a = fwd_sel(E_rs1, M_we_rf, M_rd, W_we_rf, W_rd);
  assign fwd_b = fwd_sel(E_rs2, M_we_rf, M_rd, W_we_rf, W_rd);

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decode control through E/M/W registers; E/M/W lag D by 1/2/3 edges, hazards are combinational.
// No downstream backpressure: M/W always advance, E takes a bubble on flush, stall_F/stall_D hold upstream.
module ctrl_pipeline
  import riscv_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          D_jump,
  input  logic          D_branch,
  input  logic          D_we_dm,
  input  logic          D_sel_alu_src_b,
  input  logic          D_we_rf,
  input  logic [1:0]    D_sel_result,
  input  logic [3:0]    D_alu_control,
  input  logic [RW-1:0] D_rs1,
  input  logic [RW-1:0] D_rs2,
  input  logic [RW-1:0] D_rd,
  input  logic          E_zero,
  output logic          E_jump,
  output logic          E_branch,
  output logic          E_we_dm,
  output logic          E_sel_alu_src_b,
  output logic          E_we_rf,
  output logic [1:0]    E_sel_result,
  output logic [3:0]    E_alu_control,
  output logic [RW-1:0] E_rd,
  output logic          M_we_dm,
  output logic          M_we_rf,
  output logic [1:0]    M_sel_result,
  output logic [RW-1:0] M_rd,
  output logic          W_we_rf,
  output logic [1:0]    W_sel_result,
  output logic [RW-1:0] W_rd,
  output logic [1:0]    E_fwd_a,
  output logic [1:0]    E_fwd_b,
  output logic          E_pc_src,
  output logic          stall_F,
  output logic          stall_D,
  output logic          flush_D
);

  ctrl_word_t    d_ctrl;
  ctrl_word_t    e_ctrl;
  logic [RW-1:0] e_rs1;
  logic [RW-1:0] e_rs2;
  logic [RW-1:0] e_rd;

  logic          m_we_dm;
  logic          m_we_rf;
  logic [1:0]    m_sel_result;
  logic [RW-1:0] m_rd;

  logic          w_we_rf;
  logic [1:0]    w_sel_result;
  logic [RW-1:0] w_rd;

  logic          flush_e;

  assign d_ctrl = '{
    jump:          D_jump,
    branch:        D_branch,
    we_dm:         D_we_dm,
    sel_alu_src_b: D_sel_alu_src_b,
    we_rf:         D_we_rf,
    sel_result:    D_sel_result,
    alu_control:   D_alu_control
  };

  // A bubble is an all-zero control word: no writes, no redirect, ALU result select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ctrl <= '0;
      e_rs1  <= '0;
      e_rs2  <= '0;
      e_rd   <= '0;
    end else if (flush_e) begin
      e_ctrl <= '0;
      e_rs1  <= '0;
      e_rs2  <= '0;
      e_rd   <= '0;
    end else begin
      e_ctrl <= d_ctrl;
      e_rs1  <= D_rs1;
      e_rs2  <= D_rs2;
      e_rd   <= D_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we_dm      <= 1'b0;
      m_we_rf      <= 1'b0;
      m_sel_result <= '0;
      m_rd         <= '0;
      w_we_rf      <= 1'b0;
      w_sel_result <= '0;
      w_rd         <= '0;
    end else begin
      m_we_dm      <= e_ctrl.we_dm;
      m_we_rf      <= e_ctrl.we_rf;
      m_sel_result <= e_ctrl.sel_result;
      m_rd         <= e_rd;
      w_we_rf      <= m_we_rf;
      w_sel_result <= m_sel_result;
      w_rd         <= m_rd;
    end
  end

  assign E_jump          = e_ctrl.jump;
  assign E_branch        = e_ctrl.branch;
  assign E_we_dm         = e_ctrl.we_dm;
  assign E_sel_alu_src_b = e_ctrl.sel_alu_src_b;
  assign E_we_rf         = e_ctrl.we_rf;
  assign E_sel_result    = e_ctrl.sel_result;
  assign E_alu_control   = e_ctrl.alu_control;
  assign E_rd            = e_rd;

  assign M_we_dm      = m_we_dm;
  assign M_we_rf      = m_we_rf;
  assign M_sel_result = m_sel_result;
  assign M_rd         = m_rd;

  assign W_we_rf      = w_we_rf;
  assign W_sel_result = w_sel_result;
  assign W_rd         = w_rd;

  hazard_unit #(
    .RW(RW)
  ) u_hazard (
    .E_jump      (e_ctrl.jump),
    .E_branch    (e_ctrl.branch),
    .E_zero      (E_zero),
    .E_sel_result(e_ctrl.sel_result),
    .E_rd        (e_rd),
    .E_rs1       (e_rs1),
    .E_rs2       (e_rs2),
    .D_rs1       (D_rs1),
    .D_rs2       (D_rs2),
    .M_we_rf     (m_we_rf),
    .M_rd        (m_rd),
    .W_we_rf     (w_we_rf),
    .W_rd        (w_rd),
    .pc_src      (E_pc_src),
    .flush_E     (flush_e),
    .flush_D     (flush_D),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .fwd_a       (E_fwd_a),
    .fwd_b       (E_fwd_b)
  );

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Carries the decode-stage control word through the execute, memory and writeback pipeline registers of the pipelined RV32 core, and produces every hazard response the datapath needs: operand forwarding selects, load-use stall, and redirect flush on taken branch/jump. It is the consumer side of the decode controller's `D_*` outputs. It sits between the instruction decoder and the E/M/W datapath registers.

## Interface

**Parameters**
- `RW`, default 5: register-index width.

**Ports**
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `D_jump`, `D_branch`, `D_we_dm`, `D_sel_alu_src_b`, `D_we_rf`, in, 1 each: decoded control bits.
- `D_sel_result`, in, 2: result mux select; 00 = ALU, 01 = load, 10 = PC+4, 11 = immediate.
- `D_alu_control`, in, 4: ALU operation.
- `D_rs1`, `D_rs2`, `D_rd`, in, RW each: register indices of the instruction in decode.
- `E_zero`, in, 1: ALU zero flag of the instruction in execute.
- `E_jump`, `E_branch`, `E_we_dm`, `E_sel_alu_src_b`, `E_we_rf`, out, 1 each: execute-stage control.
- `E_sel_result`, out, 2: execute-stage result select.
- `E_alu_control`, out, 4: execute-stage ALU operation.
- `E_rd`, out, RW: execute-stage destination register.
- `M_we_dm`, `M_we_rf`, out, 1 each: memory-stage control.
- `M_sel_result`, out, 2: memory-stage result select.
- `M_rd`, out, RW: memory-stage destination register.
- `W_we_rf`, out, 1: writeback-stage register-file write enable.
- `W_sel_result`, out, 2: writeback-stage result select.
- `W_rd`, out, RW: writeback-stage destination register.
- `E_fwd_a`, `E_fwd_b`, out, 2 each: operand forwarding selects; 00 = register file, 01 = W result, 10 = M ALU result.
- `E_pc_src`, out, 1: redirect fetch to the branch/jump target.
- `stall_F`, `stall_D`, out, 1 each: hold the PC register and the F/D register.
- `flush_D`, out, 1: clear the F/D register.

## Operation

**E register**
- Captures all `D_*` control signals, plus `D_rs1`, `D_rs2` and `D_rd`, every cycle.
- On flush it loads a bubble: all control bits 0, all indices 0.

**M and W registers**
- These registers never stall or flush.
- M captures E's `we_dm`, `we_rf`, `sel_result` and `rd`.
- W captures M's `we_rf`, `sel_result` and `rd`.

**Internal signals**
- `pc_src = E_jump | (E_branch & E_zero)`.
- `lw_stall = (E_sel_result == 01) & (E_rd != 0) & ((E_rd == D_rs1) | (E_rd == D_rs2))`.
- `flush_E` (internal) `= pc_src | lw_stall`.

**Hazard outputs**
- `E_pc_src = pc_src`.
- `flush_D = pc_src`.
- `stall_F = stall_D = lw_stall & ~pc_src`. When a redirect is taken, the stalled decode instruction is discarded anyway, so fetch must advance to the target.

**Forwarding for operand A** (B is identical using E_rs2)
- Select 10 if `E_rs1 != 0 & M_we_rf & M_rd == E_rs1`.
- Else 01 if `E_rs1 != 0 & W_we_rf & W_rd == E_rs1`.
- Else 00.
- M has priority over W (younger producer wins).
- Register x0 is never forwarded.

**Not handled here**
- `D_sel_ext` is consumed in decode and is not pipelined through this block.

## Timing

- **Reset:** while `rst` is high, every pipeline register is 0 asynchronously. Consequently every `E_*`, `M_*` and `W_*` output is 0, both fwd selects are 00, and `E_pc_src`, `stall_F`, `stall_D` and `flush_D` are 0. The first edge after release captures `D_*` normally.
- **Latency:** a `D_*` value sampled at edge n appears on `E_*` after edge n, on `M_*` after n+1, and on `W_*` after n+2.
- **Registered vs combinational:** all hazard outputs are combinational from the current register state and the `D_*` inputs; there are no registered hazard outputs.
- **Load-use stall:** produces exactly one bubble. Cycle k has `lw_stall` = 1; at edge k+1 the E register takes a bubble while the decode instruction is held. In cycle k+1, `E_sel_result` is 00, so `lw_stall` is 0 and the consumer proceeds with W→E forwarding available in cycle k+2.
- **Taken branch/jump:** in the cycle where `pc_src` = 1, `flush_D` is 1 and the E register loads a bubble at the next edge. That makes two squashed slots total.
- **Simultaneous load-use and redirect:** the flush wins and stalls are suppressed.
- **Reset mid-operation:** all in-flight control is dropped, so no stores or register writes are issued after assertion.

## Structure

- **Shared package `riscv_ctrl_pkg`:** holds `sel_result` encodings (RES_ALU=00, RES_LOAD=01, RES_PC4=10, RES_IMM=11), forwarding encodings (FWD_RF=00, FWD_W=01, FWD_M=10) and the control-word widths. The decode controller imports the same package.
- **Sub-module `hazard_unit`:** purely combinational; computes `pc_src`, `lw_stall`, the forward selects, and the stall/flush outputs. `ctrl_pipeline` holds only the E/M/W registers and instantiates it.

## Test plan

- **Reset:** assert `rst` mid-stream with `D_we_rf` = 1 and `D_we_dm` = 1 → all outputs read 0 immediately (before any clock edge); after release, `D_rd` = 7 appears on `W_rd` three edges later.
- **Forwarding priority:** back-to-back R-type `x5←`, `x5←`, then a consumer reading rs1 = 5 → `E_fwd_a` = 10 (M wins over W). With one independent instruction between producer and consumer → `E_fwd_a` = 01. With rd = 0 producer → `E_fwd_a` = 00.
- **Load-use:** load `x3` followed by a consumer with rs2 = 3 → `stall_F`, `stall_D` = 1 for exactly one cycle, E bubble (`E_we_rf` = 0), then `E_fwd_b` = 01 the following cycle.
- **JAL:** JAL in E (`E_jump` = 1) → `E_pc_src` = 1 and `flush_D` = 1 for one cycle; the next `E_*` is all zeros; JAL writes rd via `W_sel_result` = 10.
- **Branch:** branch with `E_zero` = 0 → no flush. With `E_zero` = 1 and simultaneous `lw_stall` conditions → `flush_D` = 1, `stall_F` = `stall_D` = 0.
- **Store:** store in flight → `M_we_dm` = 1 exactly one cycle, `W_we_rf` = 0.
